pdm_modulator_mc: RTL and testbench

PDM_MODULATOR_MC -- requirements
Module: pdm_modulator_mc

---
 rtl/pdm_modulator_mc.sv | 139 +++++++++++++
 tb/tb_pdm_modulator_mc.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_modulator_mc.sv
// Multichannel first/second-order PDM modulator with a one-deep sample buffer.
// Optional triangular-free LFSR dither is compiled in with PDM_MOD_DITHER_EN.
module pdm_modulator_mc #(
  parameter int W     = 16,
  parameter int CH    = 2,
  parameter int ORDER = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ock,
  input  logic          en,
  input  logic [CH*W-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [CH-1:0] sdo,
  output logic          sdo_stb,
  output logic          underflow,
  input  logic          clr_uf
);

  localparam int IW = W + 3;
  localparam int SW = W + 5;
  localparam logic signed [SW-1:0] HALF = $signed(SW'(32'd1) << (W - 1));
  localparam logic signed [SW-1:0] IMAX = $signed(SW'({(IW-1){1'b1}}));
  localparam logic signed [SW-1:0] IMIN = ~IMAX;
  localparam logic [W-1:0]         MID  = {1'b1, {(W-1){1'b0}}};

  function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [IW-1:0] r;
    if (v > IMAX) r = IMAX[IW-1:0];
    else if (v < IMIN) r = IMIN[IW-1:0];
    else r = v[IW-1:0];
    return r;
  endfunction

  logic sync1_r, sync2_r, sync3_r;
  logic tick_s, run_s, accept_s;
  logic full_r;
  logic [CH*W-1:0] hold_r, active_r, act_eff_s;

  assign tick_s    = sync2_r & ~sync3_r;
  assign run_s     = tick_s & en;
  assign accept_s  = din_valid & ~full_r;
  assign din_ready = ~full_r;
  // A tick that finds a full buffer modulates the sample it is consuming.
  assign act_eff_s = full_r ? hold_r : active_r;

  // ock synchroniser plus edge-detect flop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= ock;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // sample buffer, underflow flag and output strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_r    <= 1'b0;
      hold_r    <= {(CH*W){1'b0}};
      active_r  <= {CH{MID}};
      underflow <= 1'b0;
      sdo_stb   <= 1'b0;
    end else begin
      if (accept_s) hold_r <= din;
      if (run_s && full_r) begin
        active_r <= hold_r;
        full_r   <= 1'b0;
      end else if (accept_s) begin
        full_r <= 1'b1;
      end
      underflow <= (run_s & ~full_r) | (underflow & ~clr_uf);
      sdo_stb   <= run_s;
    end
  end

`ifdef PDM_MOD_DITHER_EN
  logic [15:0] lfsr_r;

  // dither LFSR, restarted from the seed while disabled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr_r <= 16'hACE1;
    else if (!en) lfsr_r <= 16'hACE1;
    else if (tick_s) lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
  end
`endif

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic signed [IW-1:0] i1_r, i2_r, i1_nxt_s, i2_nxt_s;
    logic signed [SW-1:0] xs_s, fb_s, dith_s, y_s, sum_s;
    logic bit_r, bit_nxt_s;

    // noise-shaping loop for one channel
    always_comb begin
      xs_s = $signed({{(SW-W){1'b0}}, act_eff_s[k*W +: W]}) - HALF;
      fb_s = bit_r ? HALF : -HALF;
`ifdef PDM_MOD_DITHER_EN
      dith_s = $signed({{(SW-4){1'b0}}, lfsr_r[k % 16 +: 4]}) - $signed(SW'(32'd8));
`else
      dith_s = {SW{1'b0}};
`endif
      i1_nxt_s = sat(SW'(i1_r) + xs_s - fb_s);
      if (ORDER == 1) begin
        i2_nxt_s = {IW{1'b0}};
        y_s      = SW'(i1_nxt_s);
      end else begin
        i2_nxt_s = sat(SW'(i2_r) + SW'(i1_nxt_s) - fb_s);
        y_s      = SW'(i2_nxt_s);
      end
      sum_s     = y_s + dith_s;
      bit_nxt_s = ~sum_s[SW-1];
    end

    // integrator and output bit state
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        i1_r  <= {IW{1'b0}};
        i2_r  <= {IW{1'b0}};
        bit_r <= 1'b0;
      end else if (!en) begin
        i1_r  <= {IW{1'b0}};
        i2_r  <= {IW{1'b0}};
        bit_r <= 1'b0;
      end else if (tick_s) begin
        i1_r  <= i1_nxt_s;
        i2_r  <= i2_nxt_s;
        bit_r <= bit_nxt_s;
      end
    end

    assign sdo[k] = bit_r;
  end

endmodule

// File: tb/tb_pdm_modulator_mc.sv
// Scoreboard bench for pdm_modulator_mc: ORDER=1 and ORDER=2 instances share stimulus.
module tb_pdm_modulator_mc;
  logic clk = 1'b0, rstn = 1'b0, ock = 1'b0, en = 1'b0, din_valid = 1'b0, clr_uf = 1'b0;
  logic [31:0] din = 32'd0;
  logic din_ready1, din_ready2, stb1, stb2, uf1, uf2;
  logic [1:0] sdo1, sdo2;

  always #5 clk = ~clk;

  pdm_modulator_mc #(.W(16), .CH(2), .ORDER(1)) u_o1 (
    .clk(clk), .rstn(rstn), .ock(ock), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(din_ready1), .sdo(sdo1), .sdo_stb(stb1), .underflow(uf1), .clr_uf(clr_uf));
  pdm_modulator_mc #(.W(16), .CH(2), .ORDER(2)) u_o2 (
    .clk(clk), .rstn(rstn), .ock(ock), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(din_ready2), .sdo(sdo2), .sdo_stb(stb2), .underflow(uf2), .clr_uf(clr_uf));

  int n_cmp = 0, n_fail = 0;
  logic [1:0] q1[$], q2[$];
  logic [1:0] bits1 [0:4095];
  int tot1 = 0, tot2 = 0, stb2_cnt = 0;
  int ones1 [2] = '{0, 0};
  int ones2 [2] = '{0, 0};

  int mi1 [2][2], mi2 [2][2];
  bit mpv [2][2];
  int act_m [2], hold_m [2];
  bit full_m, uf_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string nm, input int v, input int lo, input int hi);
    n_cmp++;
    if (v < lo || v > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, v, lo, hi);
    end
  endtask

  function automatic int sat_i(input int v);
    if (v > 262143) return 262143;
    if (v < -262144) return -262144;
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        mi1[d][c] = 0; mi2[d][c] = 0; mpv[d][c] = 1'b0;
      end
    act_m = '{32768, 32768};
    full_m = 1'b0;
    uf_m = 1'b0;
  endtask

  // monitor: pop expected bits whenever a strobe is presented
  always @(negedge clk) begin
    if (stb1) begin
      if (q1.size() == 0) chk("o1_unexpected_stb", 32'd1, 32'd0);
      else chk("o1_sdo", {30'd0, sdo1}, {30'd0, q1.pop_front()});
      if (tot1 < 4096) bits1[tot1] = sdo1;
      tot1++;
      for (int c = 0; c < 2; c++) ones1[c] += int'(sdo1[c]);
    end
    if (stb2) begin
      if (q2.size() == 0) chk("o2_unexpected_stb", 32'd1, 32'd0);
      else chk("o2_sdo", {30'd0, sdo2}, {30'd0, q2.pop_front()});
      tot2++;
      stb2_cnt++;
      for (int c = 0; c < 2; c++) ones2[c] += int'(sdo2[c]);
    end
  end

  task automatic load(input int s0, input int s1);
    @(negedge clk);
    chk("din_ready", {31'd0, din_ready2}, {31'd0, !full_m});
    din = {s1[15:0], s0[15:0]};
    din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    if (!full_m) begin
      hold_m = '{s0, s1};
      full_m = 1'b1;
    end
  endtask

  task automatic do_tick(input bit give, input int s0, input int s1, input bit clr);
    int xs, fb, y;
    bit evt;
    if (give) load(s0, s1);
    evt = 1'b0;
    if (en) begin
      if (full_m) begin
        act_m = hold_m;
        full_m = 1'b0;
      end else evt = 1'b1;
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 2; c++) begin
          xs = act_m[c] - 32768;
          fb = mpv[d][c] ? 32768 : -32768;
          mi1[d][c] = sat_i(mi1[d][c] + xs - fb);
          if (d == 1) mi2[d][c] = sat_i(mi2[d][c] + mi1[d][c] - fb);
          y = (d == 1) ? mi2[d][c] : mi1[d][c];
          mpv[d][c] = (y >= 0);
        end
      q1.push_back({mpv[0][1], mpv[0][0]});
      q2.push_back({mpv[1][1], mpv[1][0]});
    end else begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 2; c++) begin
          mi1[d][c] = 0; mi2[d][c] = 0; mpv[d][c] = 1'b0;
        end
    end
    uf_m = evt | (uf_m & ~clr);
    @(negedge clk); ock = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); clr_uf = clr;
    @(posedge clk);
    @(negedge clk); clr_uf = 1'b0;
    chk("stb_latency", {31'd0, stb2}, {31'd0, en});
    chk("underflow", {31'd0, uf2}, {31'd0, uf_m});
    if (!en) chk("sdo_off", {30'd0, sdo2}, 32'd0);
    repeat (5) @(negedge clk);
    ock = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    chk("queue_drained", q1.size() + q2.size(), 32'd0);
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    model_reset();
  endtask

  task automatic clr_pulse();
    @(negedge clk); clr_uf = 1'b1;
    @(negedge clk); clr_uf = 1'b0;
    uf_m = 1'b0;
    chk("uf_cleared", {31'd0, uf2}, 32'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, base, sc;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_din_ready", {31'd0, din_ready2}, 32'd1);
    chk("rst_sdo", {28'd0, sdo1, sdo2}, 32'd0);
    chk("rst_stb_uf", {30'd0, stb2, uf2}, 32'd0);
    rstn = 1'b1;
    en = 1'b1;

    // midscale on ORDER=1: bits 1,1,0 then alternating
    base = tot1; b0 = ones1[0]; b1 = ones1[1];
    for (int t = 0; t < 256; t++) do_tick(1'b1, 32'h8000, 32'h8000, 1'b0);
    chk("o1_bit0", {30'd0, bits1[base]},     32'd3);
    chk("o1_bit1", {30'd0, bits1[base + 1]}, 32'd3);
    chk("o1_bit2", {30'd0, bits1[base + 2]}, 32'd0);
    chk_rng("o1_ones_ch0", ones1[0] - b0, 127, 129);
    chk_rng("o1_ones_ch1", ones1[1] - b1, 127, 129);
    do_reset();

    // full scale on ORDER=2: saturation, no wrap
    b0 = ones2[0]; b1 = ones2[1];
    for (int t = 0; t < 256; t++) do_tick(1'b1, 32'hFFFF, 32'h0000, 1'b0);
    chk_rng("o2_ones_max", ones2[0] - b0, 254, 256);
    chk_rng("o2_ones_min", ones2[1] - b1, 0, 2);
    do_reset();

    // underflow: withheld samples repeat, clear, set wins over clear
    for (int t = 0; t < 4; t++) do_tick(1'b1, 32'h4000, 32'hC000, 1'b0);
    for (int t = 0; t < 3; t++) do_tick(1'b0, 0, 0, 1'b0);
    clr_pulse();
    do_tick(1'b0, 0, 0, 1'b1);
    for (int t = 0; t < 2; t++) do_tick(1'b1, 32'h2000, 32'hE000, 1'b0);
    clr_pulse();
    do_reset();

    // 0.75 density on ORDER=2 and strobe count
    b0 = ones2[0]; sc = stb2_cnt;
    for (int t = 0; t < 1024; t++) do_tick(1'b1, 32'hC000, 32'h8000, 1'b0);
    chk_rng("o2_density_c000", ones2[0] - b0, 758, 778);
    chk("stb_count", stb2_cnt - sc, 32'd1024);

    // reset mid-stream with a held sample, then disabled ticks
    for (int t = 0; t < 3; t++) do_tick(1'b1, 32'hFFFF, 32'hFFFF, 1'b0);
    load(32'h8000, 32'h8000);
    load(32'h1234, 32'h1234);
    chk("full_not_ready", {31'd0, din_ready2}, 32'd0);
    chk("queue_drained", q1.size() + q2.size(), 32'd0);
    @(negedge clk); #2 rstn = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, din_ready2}, 32'd1);
    chk("midrst_sdo", {28'd0, sdo1, sdo2}, 32'd0);
    @(negedge clk); rstn = 1'b1;
    model_reset();
    load(32'hC000, 32'h4000);
    en = 1'b0;
    for (int t = 0; t < 10; t++) do_tick(1'b0, 0, 0, 1'b0);
    chk("en0_keeps_hold", {31'd0, din_ready2}, 32'd0);
    en = 1'b1;
    do_tick(1'b0, 0, 0, 1'b0);
    chk("en1_consumed", {31'd0, din_ready2}, 32'd1);
    for (int t = 0; t < 4; t++) do_tick(1'b1, 32'hC000, 32'h4000, 1'b0);
    chk("final_queues", q1.size() + q2.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
